// File: rtl/mem_model_burst_if.sv
// Request/response channel bundle for the burst memory model.
// Latency: none, this is wiring only.
// Backpressure: req_ready throttles requests and resp_ready stalls response beats.
// Signals: req_* (request channel), resp_* (response channel), outstanding (queued plus in-progress count).
interface mem_model_burst_if #(
  parameter int DATA_W      = 32,
  parameter int BURST_MAX   = 8,
  parameter int QUEUE_DEPTH = 4
);
  logic                           req_valid;
  logic                           req_ready;
  logic                           req_we;
  logic [31:0]                    req_addr;
  logic [DATA_W-1:0]              req_wdata;
  logic [DATA_W/8-1:0]            req_be;
  logic [$clog2(BURST_MAX)-1:0]   req_len;
  logic                           resp_valid;
  logic                           resp_ready;
  logic [DATA_W-1:0]              resp_rdata;
  logic                           resp_we;
  logic                           resp_last;
  logic                           resp_err;
  logic [$clog2(QUEUE_DEPTH):0]   outstanding;

  // Requester side: the cache refill/writeback port.
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, req_len, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_we, resp_last, resp_err, outstanding
  );

  // Memory model side.
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, req_len, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_we, resp_last, resp_err, outstanding
  );
endinterface

// File: rtl/mem_model_burst.sv
// Bench memory model: byte-enabled writes, wrapping read bursts, in-order queue of outstanding requests.
// Latency: first beat LATENCY cycles after acceptance, later if earlier requests are still draining.
// Backpressure: req_ready from registered occupancy only; resp_* hold stable while resp_ready is low.
// Ports: clk, rst_n (async, active-low); bus = slave side of mem_model_burst_if (req_*, resp_*, outstanding).
module mem_model_burst #(
  parameter int DATA_W      = 32,
  parameter int MEM_WORDS   = 4096,
  parameter int LATENCY     = 2,
  parameter int BURST_MAX   = 8,
  parameter int QUEUE_DEPTH = 4
) (
  input logic              clk,
  input logic              rst_n,
  mem_model_burst_if.slave bus
);
  localparam int OFF   = $clog2(DATA_W / 8);
  localparam int IDX   = $clog2(MEM_WORDS);
  localparam int LEN_W = $clog2(BURST_MAX);
  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;
  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int NBE   = DATA_W / 8;

  typedef struct packed {
    logic             we;
    logic             err;
    logic [IDX-1:0]   idx;
    logic [LEN_W-1:0] len;
    logic [31:0]      ts;   // cycle counter value at the acceptance edge
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BEAT} state_t;

  logic [DATA_W-1:0] mem [MEM_WORDS];
  entry_t            q   [QUEUE_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr, rd_ptr_inc;
  logic [CNT_W-1:0]  count, count_d;
  logic [31:0]       cycle;
  state_t            state_q, state_d;

  logic              req_ready_q, resp_valid_q, resp_we_q, resp_last_q, resp_err_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic [LEN_W-1:0]  beat_q;

  logic              accept, retire, pop, req_oor;
  logic [IDX-1:0]    req_idx;
  entry_t            new_e, head, nxt, load_e;
  logic              head_elig, nxt_elig, load_en;
  logic [LEN_W-1:0]  load_beat;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign accept  = bus.req_valid && req_ready_q;
  assign retire  = resp_valid_q && bus.resp_ready;
  assign pop     = retire && resp_last_q;
  assign req_oor = |(bus.req_addr >> (OFF + IDX));
  assign req_idx = bus.req_addr[OFF+IDX-1:OFF];

  always_comb begin
    new_e     = '0;
    new_e.we  = bus.req_we;
    new_e.err = req_oor;
    new_e.idx = req_idx;
    new_e.len = bus.req_we ? '0 : bus.req_len;
    new_e.ts  = cycle;
  end

  always_comb begin
    count_d = count;
    if (accept && !pop)      count_d = count + CNT_W'(1);
    else if (!accept && pop) count_d = count - CNT_W'(1);
  end

  // Eligibility of the current head and of the entry behind it; the latter lets
  // the next request start on the same edge the previous last beat retires.
  assign rd_ptr_inc = ptr_inc(rd_ptr);
  assign head       = q[rd_ptr];
  assign nxt        = q[rd_ptr_inc];
  assign head_elig  = (count != '0) && ((cycle - head.ts) >= 32'(LATENCY));
  assign nxt_elig   = (count > CNT_W'(1)) && ((cycle - nxt.ts) >= 32'(LATENCY));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    load_en   = 1'b0;
    load_e    = head;
    load_beat = '0;
    unique case (state_q)
      S_IDLE: if (accept) state_d = S_WAIT;
      S_WAIT: begin
        if (head_elig) begin
          state_d = S_BEAT;
          load_en = 1'b1;
        end
      end
      S_BEAT: begin
        if (retire) begin
          if (!resp_last_q) begin
            load_en   = 1'b1;
            load_beat = beat_q + LEN_W'(1);
          end else if (nxt_elig) begin
            load_en = 1'b1;
            load_e  = nxt;
          end else begin
            state_d = (count_d != '0) ? S_WAIT : S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      cycle       <= '0;
      req_ready_q <= 1'b0;
      for (int i = 0; i < QUEUE_DEPTH; i++) q[i] <= '0;
    end else begin
      cycle       <= cycle + 32'd1;
      count       <= count_d;
      req_ready_q <= (count_d < CNT_W'(QUEUE_DEPTH));
      if (accept) begin
        q[wr_ptr] <= new_e;
        wr_ptr    <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= rd_ptr_inc;
    end
  end

  // Writes land at the acceptance edge; out-of-range writes are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= '0;
    end else if (accept && bus.req_we && !req_oor) begin
      for (int b = 0; b < NBE; b++)
        if (bus.req_be[b]) mem[req_idx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
    end
  end

  // Read data is captured once, when the beat is loaded; a stalled beat keeps it
  // regardless of later writes. A write on the same edge is not seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= 1'b0;
      resp_we_q    <= 1'b0;
      resp_last_q  <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      beat_q       <= '0;
    end else if (load_en) begin
      resp_valid_q <= 1'b1;
      resp_we_q    <= load_e.we;
      resp_err_q   <= load_e.err;
      resp_last_q  <= load_e.we || (load_beat == load_e.len);
      resp_rdata_q <= (load_e.we || load_e.err) ? '0 : mem[load_e.idx + IDX'(load_beat)];
      beat_q       <= load_beat;
    end else if (retire) begin
      resp_valid_q <= 1'b0;
      resp_we_q    <= 1'b0;
      resp_last_q  <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_rdata  = resp_rdata_q;
  assign bus.resp_we     = resp_we_q;
  assign bus.resp_last   = resp_last_q;
  assign bus.resp_err    = resp_err_q;
  assign bus.outstanding = count;
endmodule

// File: tb/tb_mem_model_burst.sv
// Self-checking bench for mem_model_burst: vector table plus hand-written multi-cycle sequences.
// Every retired beat is compared against a scoreboard filled when each request is accepted.
// Backpressure cases: response stall with overlapping write, full request queue, mid-burst reset.
module tb_mem_model_burst;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_model_burst_if #(.DATA_W(32), .BURST_MAX(8), .QUEUE_DEPTH(4)) bus ();

  mem_model_burst #(
    .DATA_W(32), .MEM_WORDS(4096), .LATENCY(2), .BURST_MAX(8), .QUEUE_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        we;
    logic        last;
    logic        err;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [2:0]  len;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  exp_t        sb [$];
  exp_t        cur;
  logic [31:0] model [4096];
  logic [31:0] last_rdata = '0;
  logic        last_err   = 1'b0;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4096; i++) model[i] = '0;
  endtask

  // Response monitor: a beat retires at the next rising edge iff valid&&ready here.
  always @(negedge clk) begin
    if (rst_n && bus.resp_valid && bus.resp_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected_beat: got rdata 0x%08h, want no beat", bus.resp_rdata);
      end else begin
        cur = sb.pop_front();
        check("beat_rdata", bus.resp_rdata, cur.rdata);
        check("beat_we",    32'(bus.resp_we),   32'(cur.we));
        check("beat_last",  32'(bus.resp_last), 32'(cur.last));
        check("beat_err",   32'(bus.resp_err),  32'(cur.err));
        last_rdata = bus.resp_rdata;
        last_err   = bus.resp_err;
      end
    end
  end

  // Drive one request; returns 1 ns after its acceptance edge with expected beats queued.
  task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input logic [2:0] len);
    bit   seen = 1'b0;
    int   idx;
    logic oor;
    exp_t e;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_be    = be;
    bus.req_len   = len;
    for (int t = 0; t < 200 && !seen; t++) begin
      @(negedge clk);
      if (bus.req_ready) seen = 1'b1;
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL req_accept_timeout: got req_ready 0 for 200 cycles, want 1");
    end
    @(posedge clk);
    idx = int'(addr[13:2]);
    oor = |addr[31:14];
    if (we) begin
      if (!oor)
        for (int b = 0; b < 4; b++)
          if (be[b]) model[idx][8*b +: 8] = wdata[8*b +: 8];
      e.rdata = '0; e.we = 1'b1; e.last = 1'b1; e.err = oor;
      sb.push_back(e);
    end else begin
      for (int k = 0; k <= int'(len); k++) begin
        e.rdata = oor ? 32'h0 : model[(idx + k) & 4095];
        e.we    = 1'b0;
        e.last  = (k == int'(len));
        e.err   = oor;
        sb.push_back(e);
      end
    end
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int t = 0; t < 100 && !done; t++) begin
      @(posedge clk); #1;
      if (bus.outstanding == 0 && !bus.resp_valid && sb.size() == 0) done = 1'b1;
    end
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s_drain: got outstanding %0d, %0d beats pending, want 0 and 0",
               name, bus.outstanding, sb.size());
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got simulation still running, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vt [11];
    vt[0]  = '{1'b1, 32'h0000_0040, 32'h1122_3344, 4'hF, 3'd0, 32'h0,         1'b0};
    vt[1]  = '{1'b0, 32'h0000_0040, 32'h0,         4'h0, 3'd0, 32'h1122_3344, 1'b0};
    vt[2]  = '{1'b1, 32'h0000_0080, 32'hFFFF_FFFF, 4'hF, 3'd0, 32'h0,         1'b0};
    vt[3]  = '{1'b1, 32'h0000_0080, 32'hAABB_CCDD, 4'h5, 3'd0, 32'h0,         1'b0};
    vt[4]  = '{1'b0, 32'h0000_0080, 32'h0,         4'h0, 3'd0, 32'hFFBB_FFDD, 1'b0};
    vt[5]  = '{1'b0, 32'h0000_0082, 32'h0,         4'h0, 3'd0, 32'hFFBB_FFDD, 1'b0};
    vt[6]  = '{1'b0, 32'h0001_0000, 32'h0,         4'h0, 3'd0, 32'h0,         1'b1};
    vt[7]  = '{1'b1, 32'h0001_0040, 32'hDEAD_BEEF, 4'hF, 3'd0, 32'h0,         1'b1};
    vt[8]  = '{1'b0, 32'h0000_0040, 32'h0,         4'h0, 3'd0, 32'h1122_3344, 1'b0};
    vt[9]  = '{1'b1, 32'h0000_0044, 32'h1234_5678, 4'hA, 3'd0, 32'h0,         1'b0};
    vt[10] = '{1'b0, 32'h0000_0044, 32'h0,         4'h0, 3'd0, 32'h1200_5600, 1'b0};

    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_be     = '0;
    bus.req_len    = '0;
    bus.resp_ready = 1'b1;
    clear_model();

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready",   32'(bus.req_ready),   32'd0);
    check("rst_resp_valid",  32'(bus.resp_valid),  32'd0);
    check("rst_resp_rdata",  bus.resp_rdata,       32'd0);
    check("rst_resp_we",     32'(bus.resp_we),     32'd0);
    check("rst_resp_last",   32'(bus.resp_last),   32'd0);
    check("rst_resp_err",    32'(bus.resp_err),    32'd0);
    check("rst_outstanding", 32'(bus.outstanding), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", 32'(bus.req_ready), 32'd1);

    // Single-request vectors, each drained before the next.
    for (int i = 0; i < 11; i++) begin
      send(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].be, vt[i].len);
      wait_idle($sformatf("vec%0d", i));
      check($sformatf("vec%0d_rdata", i), last_rdata, vt[i].exp_rdata);
      check($sformatf("vec%0d_err", i), 32'(last_err), 32'(vt[i].exp_err));
    end

    // First beat exactly two cycles after the acceptance edge.
    send(1'b1, 32'h100, 32'hCAFE_F00D, 4'hF, 3'd0);
    wait_idle("lat_wr");
    send(1'b0, 32'h100, 32'h0, 4'h0, 3'd0);
    @(posedge clk); #1;
    check("lat_edge1_valid", 32'(bus.resp_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_edge2_valid", 32'(bus.resp_valid), 32'd1);
    check("lat_edge2_rdata", bus.resp_rdata, 32'hCAFE_F00D);
    wait_idle("lat_rd");

    // Burst wrapping from the top word back to word 0.
    send(1'b1, 32'h3FF8, 32'd1, 4'hF, 3'd0);
    send(1'b1, 32'h3FFC, 32'd2, 4'hF, 3'd0);
    send(1'b1, 32'h0000, 32'd3, 4'hF, 3'd0);
    send(1'b1, 32'h0004, 32'd4, 4'hF, 3'd0);
    wait_idle("wrap_wr");
    send(1'b0, 32'h3FF8, 32'h0, 4'h0, 3'd3);
    wait_idle("wrap_rd");
    check("wrap_last_beat", last_rdata, 32'd4);

    // Stall mid-burst while a write hits the held beat's word.
    send(1'b1, 32'h200, 32'hA0, 4'hF, 3'd0);
    send(1'b1, 32'h204, 32'hA1, 4'hF, 3'd0);
    send(1'b1, 32'h208, 32'hA2, 4'hF, 3'd0);
    send(1'b1, 32'h20C, 32'hA3, 4'hF, 3'd0);
    wait_idle("stall_pre");
    bus.resp_ready = 1'b0;
    send(1'b0, 32'h200, 32'h0, 4'h0, 3'd3);
    for (int t = 0; t < 20 && !bus.resp_valid; t++) begin
      @(posedge clk); #1;
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    check("stall_beat1_rdata", bus.resp_rdata, 32'hA1);
    send(1'b1, 32'h204, 32'h5555_5555, 4'hF, 3'd0);
    check("stall_outstanding", 32'(bus.outstanding), 32'd2);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("stall_hold_valid", 32'(bus.resp_valid), 32'd1);
      check("stall_hold_rdata", bus.resp_rdata, 32'hA1);
      check("stall_hold_last",  32'(bus.resp_last), 32'd0);
    end
    bus.resp_ready = 1'b1;
    wait_idle("stall_drain");
    send(1'b0, 32'h204, 32'h0, 4'h0, 3'd0);
    wait_idle("stall_readback");
    check("stall_write_landed", last_rdata, 32'h5555_5555);

    // Fill the request queue with responses blocked.
    bus.resp_ready = 1'b0;
    send(1'b0, 32'h200, 32'h0, 4'h0, 3'd0);
    send(1'b0, 32'h204, 32'h0, 4'h0, 3'd0);
    send(1'b0, 32'h208, 32'h0, 4'h0, 3'd0);
    send(1'b0, 32'h20C, 32'h0, 4'h0, 3'd0);
    check("full_req_ready",   32'(bus.req_ready),   32'd0);
    check("full_outstanding", 32'(bus.outstanding), 32'd4);
    fork
      send(1'b0, 32'h40, 32'h0, 4'h0, 3'd0);
      begin
        for (int c = 0; c < 3; c++) begin
          @(posedge clk); #1;
          check("full_hold_ready",       32'(bus.req_ready),   32'd0);
          check("full_hold_outstanding", 32'(bus.outstanding), 32'd4);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        check("full_after_retire_ready", 32'(bus.req_ready),   32'd1);
        check("full_after_retire_outst", 32'(bus.outstanding), 32'd3);
      end
    join
    check("full_fifth_outstanding", 32'(bus.outstanding), 32'd4);
    check("full_fifth_ready",       32'(bus.req_ready),   32'd0);
    bus.resp_ready = 1'b1;
    wait_idle("full_drain");
    check("full_fifth_rdata", last_rdata, 32'h1122_3344);

    // Reset in the middle of a long burst.
    send(1'b0, 32'h3FF0, 32'h0, 4'h0, 3'd7);
    for (int t = 0; t < 20 && !bus.resp_valid; t++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    sb.delete();
    clear_model();
    #1;
    check("midrst_resp_valid",  32'(bus.resp_valid),  32'd0);
    check("midrst_outstanding", 32'(bus.outstanding), 32'd0);
    check("midrst_req_ready",   32'(bus.req_ready),   32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    last_rdata = 32'hFFFF_FFFF;
    send(1'b0, 32'h40, 32'h0, 4'h0, 3'd0);
    wait_idle("postrst_rd");
    check("postrst_mem_cleared", last_rdata, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_model_burst.md
Name: mem_model_burst

Overview:
Parametrised testbench memory model, successor to the single-beat fixed-latency model. It adds configurable data width, depth and response latency, multi-beat read bursts, and byte-enabled writes. It also adds valid/ready handshakes on both request and response, plus an in-order queue of outstanding requests. It sits behind the cache's refill/writeback port in the L1 data-cache bench.

Parameters:
DATA_W, 32, data width in bits; multiple of 8, power of 2
MEM_WORDS, 4096, depth in DATA_W words; power of 2
LATENCY, 2, cycles from request acceptance edge to first response beat; >=1
BURST_MAX, 8, maximum read burst beats; power of 2, >=2
QUEUE_DEPTH, 4, maximum outstanding accepted requests; >=1

Ports:
clk  in  1  clock
rst_n  in  1  reset
req_valid  in  1  request present
req_ready  out  1  model can accept request
req_we  in  1  1=write, 0=read
req_addr  in  32  byte address
req_wdata  in  DATA_W  write data
req_be  in  DATA_W/8  write byte enables
req_len  in  $clog2(BURST_MAX)  read beats minus 1 (ignored for writes)
resp_valid  out  1  response beat present
resp_ready  in  1  consumer accepts beat
resp_rdata  out  DATA_W  read data (0 for writes)
resp_we  out  1  beat answers a write
resp_last  out  1  final beat of request
resp_err  out  1  request address out of range
outstanding  out  $clog2(QUEUE_DEPTH)+1  queued plus in-progress requests

Behaviour:
- Reset: rst_n asynchronous, active-low; clock clk. All memory words, the queue, and counters are cleared. Reset values: req_ready=0, resp_valid=0, resp_rdata=0, resp_we=0, resp_last=0, resp_err=0, outstanding=0. Assertion mid-burst drops all pending requests and beats silently.
- req_ready=1 when outstanding<QUEUE_DEPTH, from registered state only. When full, ready stays 0 even if a request retires in the same cycle.
- Acceptance: req_valid&&req_ready at a rising edge. The request is pushed with a timestamp from a free-running cycle counter.
- Addressing: OFF=log2(DATA_W/8) and IDX=log2(MEM_WORDS). Word index = req_addr[OFF+IDX-1:OFF]; byte-offset bits are ignored.
- Out of range: req_addr bits above OFF+IDX are nonzero. The write is dropped. A read returns 0 on every beat. resp_err=1 on every beat of that request.
- Writes: memory is updated at the acceptance edge, only on lanes with req_be set. Each write produces one response beat with resp_we=1, resp_rdata=0, resp_last=1.
- Reads: req_len+1 beats. Word index is start+k for beat k, wrapping modulo MEM_WORDS. resp_we=0, and resp_last=1 on beat req_len only.
- Latency: a request accepted at edge N presents beat 0 at edge N+LATENCY at the earliest, and later if earlier requests are still draining. Responses are strictly in acceptance order.
- Beats then issue back-to-back, one per cycle, while resp_ready=1. A beat retires at an edge where resp_valid&&resp_ready.
- Stall: while resp_valid&&!resp_ready, all resp_* outputs hold stable.
- Read data is sampled from memory on the edge the beat is first presented. A write accepted after that edge does not alter the held beat. A write accepted before that edge, including one that overlaps an earlier read, is visible.
- Head FSM states:
  - IDLE: queue empty.
  - WAIT: head age < LATENCY.
  - BEAT: presenting beats. After the last beat retires, go to BEAT on the next entry if it is eligible, otherwise WAIT or IDLE.
- outstanding: +1 on accept, -1 on last-beat retire. Both in the same cycle leaves it unchanged.
- With LATENCY=2, BURST_MAX ignored, all-ones be, and resp_ready tied 1, timing matches the legacy single-beat model.

Test Plan:
- Write 0x11223344 to 0x40, then read len=0 from 0x40 -> write beat resp_we=1 last=1; read beat 0x11223344 exactly 2 cycles after its acceptance.
- Write be=4'b0101 with data 0xAABBCCDD over 0xFFFFFFFF at 0x80, then read -> 0xFFBBFFDD.
- Preload words 4094 and 4095 and words 0 and 1 with 1,2,3,4; read len=3 at byte 0x3FF8 -> beats 1,2,3,4 with last on beat 4.
- Hold resp_ready=0 for 5 cycles mid-burst while issuing a write to the held beat's address -> held rdata is unchanged; the next beats follow in order.
- Issue 5 back-to-back reads with QUEUE_DEPTH=4 and resp_ready=0 -> req_ready drops after the 4th; outstanding=4; the 5th is accepted only after one last-beat retires.
- Read at 0x0001_0000 (out of range) -> resp_err=1, rdata=0. Assert rst_n mid-burst -> resp_valid=0, outstanding=0, memory reads back 0.
